axis_pixel_packer: RTL and testbench

Parametrised AXI4-Stream pixel compactor for the upscaler output path, placed between access control and the VDMA.
- Accepts beats of N_LANE pixel slots, some of which may be null (keep low).
- Emits dense beats with every slot valid.
- Generates tlast per destination line and tuser per frame from its own counters.
- Optional partial-beat flush on input tlast; flags input line-boundary misalignment.

---
 rtl/axis_pkg.sv | 26 ++
 rtl/pixel_compactor.sv | 33 +++
 rtl/axis_pixel_packer.sv | 153 +++++++++++++++
 tb/tb_axis_pixel_packer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared widths and keep-decoding helpers for the pixel packer.
// Default widths describe the RGB888, 4-lane configuration.
package axis_pkg;
  localparam int DEF_N_LANE    = 4;
  localparam int DEF_PIX_BYTES = 3;
  localparam int PIX_W         = DEF_PIX_BYTES * 8;
  localparam int DATA_W        = DEF_N_LANE * PIX_W;
  localparam int KEEP_W        = DEF_N_LANE * DEF_PIX_BYTES;
  localparam int MAX_KEEP_W    = 8 * 4;

  // A slot is valid when the keep bit of its first byte is set.
  function automatic logic slot_valid(input logic [MAX_KEEP_W-1:0] keep, input int i,
                                      input int pix_bytes);
    return keep[i*pix_bytes];
  endfunction

  function automatic int popcount_slots(input logic [MAX_KEEP_W-1:0] keep, input int n_lane,
                                        input int pix_bytes);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < n_lane && slot_valid(keep, i, pix_bytes)) n++;
    end
    return n;
  endfunction
endpackage

// File: rtl/pixel_compactor.sv
// Combinational slot compactor: valid slots move LSB-first in order, unused slots read zero.
module pixel_compactor
  import axis_pkg::*;
#(
  parameter int N_LANE    = DEF_N_LANE,
  parameter int PIX_BYTES = DEF_PIX_BYTES
) (
  input  logic [N_LANE*PIX_BYTES*8-1:0]   data,
  input  logic [N_LANE*PIX_BYTES-1:0]     keep,
  output logic [N_LANE*PIX_BYTES*8-1:0]   pix_out,
  output logic [$clog2(N_LANE+1)-1:0]     n_in
);
  localparam int PW = PIX_BYTES * 8;
  localparam int CW = $clog2(N_LANE + 1);

  logic [MAX_KEEP_W-1:0] keep_ext;
  int                    pos;

  assign keep_ext = MAX_KEEP_W'(keep);
  assign n_in     = CW'(popcount_slots(keep_ext, N_LANE, PIX_BYTES));

  // pos is the running prefix sum of valid slots below slot i.
  always_comb begin
    pix_out = '0;
    pos     = 0;
    for (int i = 0; i < N_LANE; i++) begin
      if (slot_valid(keep_ext, i, PIX_BYTES)) begin
        pix_out[pos*PW +: PW] = data[i*PW +: PW];
        pos++;
      end
    end
  end
endmodule

// File: rtl/axis_pixel_packer.sv
// AXI4-Stream pixel packer: compacts sparse input beats into dense output beats and
// regenerates tlast/tuser from its own line/frame counters.
module axis_pixel_packer
  import axis_pkg::*;
#(
  parameter int N_LANE         = DEF_N_LANE,
  parameter int PIX_BYTES      = DEF_PIX_BYTES,
  parameter int DST_IMG_WIDTH  = 960,
  parameter int DST_IMG_HEIGHT = 540,
  parameter bit FLUSH_ON_LAST  = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic [N_LANE*PIX_BYTES*8-1:0] s_axis_tdata,
  input  logic [N_LANE*PIX_BYTES-1:0]   s_axis_tkeep,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tuser,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [N_LANE*PIX_BYTES*8-1:0] m_axis_tdata,
  output logic [N_LANE*PIX_BYTES-1:0]   m_axis_tkeep,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  output logic                          err_misalign
);
  localparam int PW  = PIX_BYTES * 8;
  localparam int NB  = 2 * N_LANE;
  localparam int OW  = $clog2(NB + 1);
  localparam int CW  = $clog2(N_LANE + 1);
  localparam int PCW = $clog2(DST_IMG_WIDTH + N_LANE + 1);
  localparam int LCW = $clog2(DST_IMG_HEIGHT + 1);

  logic [PW-1:0]             buf_q   [NB];
  logic [PW-1:0]             buf_nxt [NB];
  logic [OW-1:0]             occ_q;
  logic [PCW-1:0]            pix_cnt_q, pix_nxt, in_cnt_q, in_cnt_nxt;
  logic [LCW-1:0]            line_cnt_q, line_nxt;
  logic                      sof_pend_q, sof_nxt, flush_pend_q, flush_nxt;
  logic                      err_q, err_set, active_q;
  logic [N_LANE*PW-1:0]      cmp_dat;
  logic [CW-1:0]             n_in;
  logic                      is_flush, out_fire, full_fire, in_fire;
  int                        occ_i, n_in_i, occ_base, occ_nxt, in_sum;

  pixel_compactor #(.N_LANE(N_LANE), .PIX_BYTES(PIX_BYTES)) u_compactor (
    .data    (s_axis_tdata),
    .keep    (s_axis_tkeep),
    .pix_out (cmp_dat),
    .n_in    (n_in)
  );

  // Handshake and occupancy; a flush beat is the partial remainder once full beats drained.
  always_comb begin
    occ_i         = int'(occ_q);
    n_in_i        = int'(n_in);
    is_flush      = flush_pend_q && (occ_i < N_LANE);
    m_axis_tvalid = (occ_i >= N_LANE) || flush_pend_q;
    out_fire      = m_axis_tvalid && m_axis_tready;
    full_fire     = out_fire && !is_flush;
    occ_base      = full_fire ? occ_i - N_LANE : occ_i;
    s_axis_tready = active_q && !flush_pend_q && (occ_base <= N_LANE);
    in_fire       = s_axis_tvalid && s_axis_tready;
    occ_nxt       = (is_flush && out_fire) ? 0 : occ_base + (in_fire ? n_in_i : 0);
  end

  for (genvar g = 0; g < N_LANE; g++) begin : g_out
    assign m_axis_tdata[g*PW +: PW] = buf_q[g];
    assign m_axis_tkeep[g*PIX_BYTES +: PIX_BYTES] =
        {PIX_BYTES{m_axis_tvalid && (!is_flush || g < occ_i)}};
  end

  assign m_axis_tlast = m_axis_tvalid && (is_flush || int'(pix_cnt_q) == DST_IMG_WIDTH - N_LANE);
  assign m_axis_tuser = m_axis_tvalid && sof_pend_q && (pix_cnt_q == '0) && (line_cnt_q == '0);
  assign err_misalign = err_q;

  // Slots at or above occ stay zero, so a flush beat's unused slots read zero.
  always_comb begin
    for (int j = 0; j < NB; j++) buf_nxt[j] = buf_q[j];
    if (is_flush && out_fire) begin
      for (int j = 0; j < NB; j++) buf_nxt[j] = '0;
    end else if (full_fire) begin
      for (int j = 0; j < NB - N_LANE; j++) buf_nxt[j] = buf_q[j+N_LANE];
      for (int j = NB - N_LANE; j < NB; j++) buf_nxt[j] = '0;
    end
    if (in_fire) begin
      for (int j = 0; j < NB; j++) begin
        if (j >= occ_base && j < occ_base + n_in_i) buf_nxt[j] = cmp_dat[(j-occ_base)*PW +: PW];
      end
    end
  end

  always_comb begin
    pix_nxt    = pix_cnt_q;
    line_nxt   = line_cnt_q;
    sof_nxt    = sof_pend_q;
    flush_nxt  = flush_pend_q;
    in_cnt_nxt = in_cnt_q;
    err_set    = 1'b0;
    in_sum     = 0;
    if (out_fire) begin
      if (m_axis_tlast) begin
        pix_nxt  = '0;
        line_nxt = (int'(line_cnt_q) == DST_IMG_HEIGHT - 1) ? '0 : line_cnt_q + LCW'(1);
      end else begin
        pix_nxt  = pix_cnt_q + PCW'(N_LANE);
      end
      if (m_axis_tuser) sof_nxt = 1'b0;
      if (is_flush) flush_nxt = 1'b0;
    end
    if (in_fire) begin
      if (s_axis_tuser) begin
        pix_nxt  = '0;
        line_nxt = '0;
        sof_nxt  = 1'b1;
        if (occ_q != '0) err_set = 1'b1;
      end
      in_sum = (s_axis_tuser ? 0 : int'(in_cnt_q)) + n_in_i;
      if (s_axis_tlast) begin
        in_cnt_nxt = '0;
        if (in_sum != DST_IMG_WIDTH) err_set = 1'b1;
        if (FLUSH_ON_LAST && (occ_nxt % N_LANE) != 0) flush_nxt = 1'b1;
      end else begin
        in_cnt_nxt = PCW'((in_sum >= DST_IMG_WIDTH) ? in_sum - DST_IMG_WIDTH : in_sum);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NB; j++) buf_q[j] <= '0;
      occ_q        <= '0;
      pix_cnt_q    <= '0;
      in_cnt_q     <= '0;
      line_cnt_q   <= '0;
      sof_pend_q   <= 1'b1;
      flush_pend_q <= 1'b0;
      err_q        <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      for (int j = 0; j < NB; j++) buf_q[j] <= buf_nxt[j];
      occ_q        <= OW'(occ_nxt);
      pix_cnt_q    <= pix_nxt;
      in_cnt_q     <= in_cnt_nxt;
      line_cnt_q   <= line_nxt;
      sof_pend_q   <= sof_nxt;
      flush_pend_q <= flush_nxt;
      if (err_set) err_q <= 1'b1;
      active_q     <= 1'b1;
    end
  end
endmodule

// File: tb/tb_axis_pixel_packer.sv
// Directed bench with queue scoreboard for the main (W=8) and flush (W=6) packer configurations.
module tb_axis_pixel_packer;
  import axis_pkg::*;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [KEEP_W-1:0] k;
    logic              l;
    logic              u;
  } beat_t;

  logic clk, rst_n;
  logic s_vld, s_rdy, s_last, s_user, m_vld, m_rdy, m_last, m_user, err;
  logic [DATA_W-1:0] s_dat, m_dat;
  logic [KEEP_W-1:0] s_keep, m_keep;
  logic sf_vld, sf_rdy, sf_last, sf_user, mf_vld, mf_rdy, mf_last, mf_user, errf;
  logic [DATA_W-1:0] sf_dat, mf_dat;
  logic [KEEP_W-1:0] sf_keep, mf_keep;

  beat_t exp_q[$], exp_qf[$], got, e, stall_val;
  bit    prev_stall;
  int    n_cmp, n_err, nxt_pix, tid;

  axis_pixel_packer #(.N_LANE(4), .PIX_BYTES(3), .DST_IMG_WIDTH(8), .DST_IMG_HEIGHT(2),
                      .FLUSH_ON_LAST(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(s_vld), .s_axis_tready(s_rdy), .s_axis_tdata(s_dat), .s_axis_tkeep(s_keep),
    .s_axis_tlast(s_last), .s_axis_tuser(s_user),
    .m_axis_tvalid(m_vld), .m_axis_tready(m_rdy), .m_axis_tdata(m_dat), .m_axis_tkeep(m_keep),
    .m_axis_tlast(m_last), .m_axis_tuser(m_user), .err_misalign(err)
  );

  axis_pixel_packer #(.N_LANE(4), .PIX_BYTES(3), .DST_IMG_WIDTH(6), .DST_IMG_HEIGHT(2),
                      .FLUSH_ON_LAST(1'b1)) u_dut_f (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tvalid(sf_vld), .s_axis_tready(sf_rdy), .s_axis_tdata(sf_dat), .s_axis_tkeep(sf_keep),
    .s_axis_tlast(sf_last), .s_axis_tuser(sf_user),
    .m_axis_tvalid(mf_vld), .m_axis_tready(mf_rdy), .m_axis_tdata(mf_dat), .m_axis_tkeep(mf_keep),
    .m_axis_tlast(mf_last), .m_axis_tuser(mf_user), .err_misalign(errf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] pix(input int k);
    return 24'(tid * 256 + k + 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual %h required %h", nm, act, req);
    end
  endtask

  task automatic push_exp(input bit f, input int k0, input int n, input bit last, input bit user);
    beat_t b;
    b = '0;
    for (int s = 0; s < n; s++) begin
      b.d[s*24 +: 24] = pix(k0 + s);
      b.k[s*3 +: 3]   = 3'b111;
    end
    b.l = last;
    b.u = user;
    if (f) exp_qf.push_back(b); else exp_q.push_back(b);
  endtask

  // Valid slots carry consecutive pixels; null slots carry junk that must be dropped.
  task automatic send(input bit f, input logic [3:0] slots, input bit last, input bit user);
    logic [DATA_W-1:0] d;
    logic [KEEP_W-1:0] k;
    bit ok;
    d = '0; k = '0; ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (slots[i]) begin
        d[i*24 +: 24] = pix(nxt_pix);
        k[i*3 +: 3]   = 3'b111;
        nxt_pix++;
      end else begin
        d[i*24 +: 24] = 24'hEE0000 + 24'(i);
      end
    end
    if (f) begin
      sf_vld = 1'b1; sf_dat = d; sf_keep = k; sf_last = last; sf_user = user;
    end else begin
      s_vld = 1'b1; s_dat = d; s_keep = k; s_last = last; s_user = user;
    end
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = f ? sf_rdy : s_rdy;
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout actual tready 0 required 1");
    end
    if (f) sf_vld = 1'b0; else s_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops on each output handshake and checks held beats stay stable.
  initial begin
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      got = {m_dat, m_keep, m_last, m_user};
      if (prev_stall) begin
        n_cmp++;
        if (!m_vld || got !== stall_val) begin
          n_err++;
          $display("FAIL stall_hold actual %h required %h", got, stall_val);
        end
      end
      prev_stall = m_vld && !m_rdy;
      stall_val  = got;
      if (m_vld && m_rdy) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL extra_beat actual %h required none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_err++;
            $display("FAIL beat actual %h required %h", got, e);
          end
        end
      end
      if (mf_vld && mf_rdy) begin
        got = {mf_dat, mf_keep, mf_last, mf_user};
        n_cmp++;
        if (exp_qf.size() == 0) begin
          n_err++;
          $display("FAIL extra_beat_f actual %h required none", got);
        end else begin
          e = exp_qf.pop_front();
          if (got !== e) begin
            n_err++;
            $display("FAIL beat_f actual %h required %h", got, e);
          end
        end
      end
    end
  end

  initial begin
    n_cmp = 0; n_err = 0; nxt_pix = 0; tid = 1;
    rst_n = 1'b0; m_rdy = 1'b1; mf_rdy = 1'b1;
    s_vld = 1'b0; s_dat = '0; s_keep = '0; s_last = 1'b0; s_user = 1'b0;
    sf_vld = 1'b0; sf_dat = '0; sf_keep = '0; sf_last = 1'b0; sf_user = 1'b0;

    #12;
    chk("rst_s_rdy", 32'(s_rdy), 0);
    chk("rst_sf_rdy", 32'(sf_rdy), 0);
    chk("rst_m_vld", 32'(m_vld), 0);
    chk("rst_m_dat_nz", 32'(m_dat != '0), 0);
    chk("rst_m_ctl", {m_keep, m_last, m_user}, 0);
    chk("rst_err", 32'(err), 0);
    @(negedge clk); rst_n = 1'b1;
    idle(1);
    chk("post_rst_s_rdy", 32'(s_rdy), 1);

    // Two dense lines; tuser only on the very first beat.
    tid = 1; nxt_pix = 0;
    push_exp(0, 0, 4, 0, 1); push_exp(0, 4, 4, 1, 0);
    push_exp(0, 8, 4, 0, 0); push_exp(0, 12, 4, 1, 0);
    send(0, 4'b1111, 0, 1); send(0, 4'b1111, 1, 0);
    send(0, 4'b1111, 0, 0); send(0, 4'b1111, 1, 0);
    idle(4);
    chk("t1_err", 32'(err), 0);

    // Sparse slot patterns starting a new frame.
    tid = 2; nxt_pix = 0;
    push_exp(0, 0, 4, 0, 1); push_exp(0, 4, 4, 1, 0);
    push_exp(0, 8, 4, 0, 0); push_exp(0, 12, 4, 1, 0);
    send(0, 4'b1010, 0, 1); send(0, 4'b0111, 0, 0); send(0, 4'b1100, 0, 0);
    send(0, 4'b0011, 0, 0); send(0, 4'b0101, 0, 0); send(0, 4'b1111, 0, 0);
    send(0, 4'b0001, 1, 0);
    idle(4);
    chk("t2_err", 32'(err), 0);

    // Output stalled for 10 cycles mid-stream.
    tid = 3; nxt_pix = 0;
    push_exp(0, 0, 4, 0, 0); push_exp(0, 4, 4, 1, 0);
    push_exp(0, 8, 4, 0, 0); push_exp(0, 12, 4, 1, 0);
    m_rdy = 1'b0;
    fork
      begin
        send(0, 4'b1111, 0, 0); send(0, 4'b1111, 1, 0);
        send(0, 4'b1111, 0, 0); send(0, 4'b1111, 1, 0);
      end
      begin
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("t3_s_rdy_stall", 32'(s_rdy), 0);
        chk("t3_m_vld_stall", 32'(m_vld), 1);
        @(posedge clk); #1;
        m_rdy = 1'b1;
      end
    join
    idle(4);
    chk("t3_err", 32'(err), 0);

    // Flush configuration: 6-pixel lines give a full beat plus a 2-slot flush beat.
    tid = 4; nxt_pix = 0;
    push_exp(1, 0, 4, 0, 1); push_exp(1, 4, 2, 1, 0);
    push_exp(1, 6, 4, 0, 0); push_exp(1, 10, 2, 1, 0);
    send(1, 4'b1111, 0, 1); send(1, 4'b0011, 1, 0);
    send(1, 4'b1111, 0, 0); send(1, 4'b0011, 1, 0);
    idle(4);
    chk("t4_errf", 32'(errf), 0);

    // Short line of 5 pixels raises a sticky misalignment.
    tid = 5; nxt_pix = 0;
    push_exp(0, 0, 4, 0, 0);
    send(0, 4'b1111, 0, 0);
    chk("t5_err_pre", 32'(err), 0);
    send(0, 4'b0100, 1, 0);
    chk("t5_err_rise", 32'(err), 1);
    idle(5);
    chk("t5_err_sticky", 32'(err), 1);

    // Reset with 3 pixels buffered; they must vanish and the next beat carries tuser.
    send(0, 4'b0011, 0, 0);
    idle(2);
    chk("t6_pre_m_dat_nz", 32'(m_dat != '0), 1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_s_rdy", 32'(s_rdy), 0);
    chk("t6_rst_m_vld", 32'(m_vld), 0);
    chk("t6_rst_m_dat_nz", 32'(m_dat != '0), 0);
    chk("t6_rst_m_ctl", {m_keep, m_last, m_user}, 0);
    chk("t6_rst_err", 32'(err), 0);
    @(negedge clk); rst_n = 1'b1;
    idle(1);
    tid = 6; nxt_pix = 0;
    push_exp(0, 0, 4, 0, 1); push_exp(0, 4, 4, 1, 0);
    send(0, 4'b1111, 0, 0); send(0, 4'b1111, 1, 0);

    for (int c = 0; c < 100 && (exp_q.size() != 0 || exp_qf.size() != 0); c++) @(posedge clk);
    idle(2);
    chk("drain_main", 32'(exp_q.size()), 0);
    chk("drain_flush", 32'(exp_qf.size()), 0);
    chk("end_err", 32'(err), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
